multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing the shared ALU, register file and single memory port of the

---
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back over a shared ALU, register file and one memory port.
`timescale 1ns/1ps

module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] branch_type_o,
  output logic       IorD_o,
  output logic       IRWrite_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALU_op_o,
  output logic [1:0] PCSource_o,
  output logic       instr_done_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ERR      = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [7:0] WAIT_LAST =
    (MEM_WAIT_MAX == 0) ? 8'd0 : 8'(MEM_WAIT_MAX - 1);
  localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [5:0] op_q;
  logic [7:0] wait_cnt;
  logic       wait_state;
  logic       timeout;

  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready on the final allowed cycle wins over the timeout.
  assign timeout    = TIMEOUT_EN && !mem_ready_i && (wait_cnt == WAIT_LAST);

  // NOTE: every combinational block assigns a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = S_ERR;
    case (state)
      S_FETCH: begin
        if (mem_ready_i)  state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_ERR;
        else              state_nxt = S_FETCH;
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:                         state_nxt = S_EXEC_R;
          OP_ADDI, OP_SLTI:                 state_nxt = S_EXEC_I;
          OP_LW, OP_SW:                     state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLTZ, OP_BGTZ: state_nxt = S_BRANCH;
          default:                          state_nxt = S_ERR;
        endcase
      end
      S_EXEC_R:   state_nxt = S_WB_ALU;
      S_EXEC_I:   state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i)  state_nxt = S_WB_MEM;
        else if (timeout) state_nxt = S_ERR;
        else              state_nxt = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready_i)  state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_ERR;
        else              state_nxt = S_MEM_WR;
      end
      S_WB_MEM: state_nxt = S_FETCH;
      S_WB_ALU: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_ERR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      op_q     <= 6'd0;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= instr_op_i;
      // Outside a wait, or once ready, the count is clear, so every wait starts at zero.
      if (wait_state && !mem_ready_i) wait_cnt <= wait_cnt + 8'd1;
      else                            wait_cnt <= 8'd0;
    end
  end

  // Moore outputs; only the fetch load strobes and the store's done pulse
  // follow mem_ready_i. Reset forces everything low, even mid-access.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    branch_type_o = 2'b00;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = 3'b000;
    PCSource_o    = 2'b00;
    instr_done_o  = 1'b0;
    err_o         = 1'b0;
    state_o       = 4'd0;
    if (!rst_i) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE: begin
          ALUSrcB_o = 2'b11;
        end
        S_EXEC_R: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b00;
          ALU_op_o  = 3'b100;
        end
        S_EXEC_I: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
          ALU_op_o  = (op_q == OP_SLTI) ? 3'b010 : 3'b000;
        end
        S_MEM_ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
        end
        S_MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite_o   = 1'b1;
          IorD_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_WB_MEM: begin
          RegWrite_o   = 1'b1;
          MemtoReg_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_WB_ALU: begin
          RegWrite_o   = 1'b1;
          RegDst_o     = (op_q == OP_RTYPE);
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = 3'b001;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 2'b01;
          instr_done_o  = 1'b1;
          case (op_q)
            OP_BNE:  branch_type_o = 2'b01;
            OP_BLTZ: branch_type_o = 2'b10;
            OP_BGTZ: branch_type_o = 2'b11;
            default: branch_type_o = 2'b00;
          endcase
        end
        default: begin
          err_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random opcode/ready/reset
// traffic, compared every cycle against an instruction-plan reference model.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 4;

  typedef enum int {
    P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_MEM_ADDR = 4,
    P_MEM_RD = 5, P_MEM_WR = 6, P_WB_MEM = 7, P_WB_ALU = 8, P_BRANCH = 9, P_ERR = 10
  } phase_t;

  localparam logic [5:0] LEGAL_OPS [9] = '{6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b,
                                           6'h04, 6'h05, 6'h01, 6'h07};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instr_op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, err;
  logic [1:0] branch_type, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [24:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, remaining phases of this instruction,
  // captured opcode and consecutive not-ready count.
  phase_t     ph = P_FETCH;
  phase_t     plan [$];
  logic [5:0] m_op = 6'd0;
  int         miss = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .mem_ready_i(mem_ready),
    .PCWrite_o(pc_write), .PCWriteCond_o(pc_write_cond), .branch_type_o(branch_type),
    .IorD_o(iord), .IRWrite_o(ir_write), .MemRead_o(mem_read), .MemWrite_o(mem_write),
    .MemtoReg_o(mem_to_reg), .RegDst_o(reg_dst), .RegWrite_o(reg_write),
    .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b), .ALU_op_o(alu_op),
    .PCSource_o(pc_source), .instr_done_o(instr_done), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, branch_type, iord, ir_write, mem_read, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, err, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] exp_outs(phase_t p, logic [5:0] op, logic rdy, logic rs);
    logic       pcw = 0, pcwc = 0, io = 0, irw = 0, mr = 0, mw = 0;
    logic       m2r = 0, rd = 0, rw = 0, sa = 0, dn = 0, er = 0;
    logic [1:0] bt = 0, sb = 0, ps = 0;
    logic [2:0] ao = 0;
    if (rs) return 25'd0;
    case (p)
      P_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE:   sb = 2'b11;
      P_EXEC_R:   begin sa = 1; ao = 3'b100; end
      P_EXEC_I:   begin sa = 1; sb = 2'b10; ao = (op == 6'h0a) ? 3'b010 : 3'b000; end
      P_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      P_MEM_RD:   begin mr = 1; io = 1; end
      P_MEM_WR:   begin mw = 1; io = 1; dn = rdy; end
      P_WB_MEM:   begin rw = 1; m2r = 1; dn = 1; end
      P_WB_ALU:   begin rw = 1; rd = (op == 6'h00); dn = 1; end
      P_BRANCH: begin
        sa = 1; ao = 3'b001; pcwc = 1; ps = 2'b01; dn = 1;
        bt = (op == 6'h05) ? 2'b01 : (op == 6'h01) ? 2'b10 : (op == 6'h07) ? 2'b11 : 2'b00;
      end
      default:    er = 1;
    endcase
    return {pcw, pcwc, bt, io, irw, mr, mw, m2r, rd, rw, sa, sb, ao, ps, dn, er, 4'(p)};
  endfunction

  task automatic next_from_plan();
    if (plan.size() == 0) ph = P_FETCH;
    else                  ph = plan.pop_front();
  endtask

  task automatic model_advance(input logic [5:0] op, input logic rdy, input logic rs);
    if (rs) begin
      ph = P_FETCH; miss = 0; plan.delete();
      return;
    end
    case (ph)
      P_ERR: ;
      P_FETCH, P_MEM_RD, P_MEM_WR: begin
        if (rdy) begin
          miss = 0;
          if (ph == P_FETCH) ph = P_DECODE;
          else               next_from_plan();
        end else begin
          miss++;
          if (WAIT_MAX != 0 && miss == WAIT_MAX) begin
            ph = P_ERR; miss = 0; plan.delete();
          end
        end
      end
      P_DECODE: begin
        m_op = op;
        plan.delete();
        case (op)
          6'h00:               plan = '{P_EXEC_R, P_WB_ALU};
          6'h08, 6'h0a:        plan = '{P_EXEC_I, P_WB_ALU};
          6'h23:               plan = '{P_MEM_ADDR, P_MEM_RD, P_WB_MEM};
          6'h2b:               plan = '{P_MEM_ADDR, P_MEM_WR};
          6'h04, 6'h05, 6'h01, 6'h07: plan = '{P_BRANCH};
          default:             plan = '{P_ERR};
        endcase
        next_from_plan();
      end
      default: next_from_plan();
    endcase
  endtask

  // One clock: drive on the falling edge, compare 1 ns later, advance model at the rising edge.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rs,
                      output logic [24:0] o);
    @(negedge clk);
    instr_op = op; mem_ready = rdy; rst = rs;
    #1;
    o = obs;
    check($sformatf("outs_ph%0d", int'(ph)), 32'(obs), 32'(exp_outs(ph, m_op, rdy, rs)));
    @(posedge clk);
    model_advance(op, rdy, rs);
  endtask

  // Runs one instruction from FETCH, stalling the given number of not-ready
  // cycles in fetch and in the memory phase, and checks total latency.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int exp_cyc, input string tag);
    int n = 0;
    int fs = fstall;
    int ms = mstall;
    logic rdy;
    logic [24:0] o = '0;
    while (o[5] !== 1'b1 && n < 40) begin
      rdy = 1'b1;
      if (ph == P_FETCH && fs > 0) begin rdy = 1'b0; fs--; end
      else if ((ph == P_MEM_RD || ph == P_MEM_WR) && ms > 0) begin rdy = 1'b0; ms--; end
      step(op, rdy, 1'b0, o);
      n++;
    end
    check(tag, 32'(n), 32'(exp_cyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] o;
    logic [5:0]  op;
    logic        rdy, rs;

    step(6'd0, 1'b0, 1'b1, o);
    step(6'd0, 1'b1, 1'b1, o);
    check("rst_outputs_zero", 32'(o), 32'd0);

    run_instr(6'h00, 0, 0, 4, "lat_rtype");
    run_instr(6'h23, 0, 2, 7, "lat_lw_stall2");
    run_instr(6'h05, 0, 0, 3, "lat_bne");
    run_instr(6'h2b, 0, 0, 4, "lat_sw");
    run_instr(6'h08, 0, 0, 4, "lat_addi");
    run_instr(6'h0a, 0, 0, 4, "lat_slti");
    run_instr(6'h04, 0, 0, 3, "lat_beq");
    run_instr(6'h01, 0, 0, 3, "lat_bltz");
    run_instr(6'h07, 0, 0, 3, "lat_bgtz");
    run_instr(6'h23, 3, 1, 9, "lat_lw_fstall3");
    run_instr(6'h2b, 0, 3, 7, "lat_sw_stall3");

    // Illegal opcode: DECODE then sticky ERR until reset.
    step(6'h3f, 1'b1, 1'b0, o);
    step(6'h3f, 1'b1, 1'b0, o);
    check("illegal_decode_state", 32'(o[3:0]), 32'd1);
    for (int i = 0; i < 20; i++) step(6'($urandom), 1'($urandom), 1'b0, o);
    check("err_sticky", 32'(o[4]), 32'd1);
    step(6'd0, 1'b0, 1'b1, o);
    step(6'd0, 1'b0, 1'b0, o);
    check("err_cleared_state", 32'(o[3:0]), 32'd0);
    check("err_cleared_flag", 32'(o[4]), 32'd0);

    // Timeout after the 4th consecutive not-ready fetch cycle.
    for (int i = 0; i < 3; i++) step(6'd0, 1'b0, 1'b0, o);
    step(6'd0, 1'b0, 1'b0, o);
    step(6'd0, 1'b0, 1'b0, o);
    check("timeout_err", 32'(o[4]), 32'd1);
    step(6'd0, 1'b0, 1'b1, o);
    // Ready on the 4th cycle completes the fetch instead.
    for (int i = 0; i < 3; i++) step(6'd0, 1'b0, 1'b0, o);
    step(6'd0, 1'b1, 1'b0, o);
    check("late_ready_irwrite", 32'(o[19]), 32'd1);
    step(6'h00, 1'b1, 1'b0, o);
    check("late_ready_decode", 32'(o[3:0]), 32'd1);
    step(6'd0, 1'b1, 1'b0, o);
    step(6'd0, 1'b1, 1'b0, o);

    // Reset while a store is waiting in MEM_WR.
    step(6'h2b, 1'b1, 1'b0, o);
    step(6'h2b, 1'b1, 1'b0, o);
    step(6'h2b, 1'b1, 1'b0, o);
    step(6'h2b, 1'b0, 1'b0, o);
    check("memwr_state", 32'(o[3:0]), 32'd6);
    step(6'h2b, 1'b1, 1'b1, o);
    check("rst_memwrite", 32'(o[17]), 32'd0);
    step(6'h2b, 1'b0, 1'b0, o);
    check("post_rst_state", 32'(o[3:0]), 32'd0);
    check("post_rst_memread", 32'(o[18]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) op = 6'($urandom);
      else                            op = LEGAL_OPS[$urandom_range(0, 8)];
      rdy = ($urandom_range(0, 9) < 7);
      rs  = ($urandom_range(0, 59) == 0);
      step(op, rdy, rs, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
